// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for the fetch and memory stages.
// One transaction in flight at a time; data wins by default, a streak
// counter forces a fetch grant after MAX_DSTREAK consecutive data grants
// while fetch waits, and a timeout forces completion if memory never answers.
module mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ready,
    output logic [31:0]           if_rdata,
    output logic                  stall_f,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic                  dm_ready,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  stall_m,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_valid,
    output logic                  err
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(MAX_DSTREAK + 1);
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_F = 3'd1,
        WAIT_D = 3'd2,
        RESP_F = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [SW-1:0]       streak_r;
    logic [CW-1:0]       tmo_cnt_r;
    logic                grant_f_s;
    logic                grant_d_s;
    logic                capture_s;
    logic                expire_s;
    logic                done_s;
    logic                wait_f_s;
    logic                wait_d_s;
    logic                fsel_r;
    logic                if_ready_r;
    logic [31:0]         if_rdata_r;
    logic                dm_ready_r;
    logic [DATA_W-1:0]   dm_rdata_r;
    logic                mem_en_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [BE_W-1:0]     mem_be_r;
    logic                err_r;
    logic                addr_unused_s;

    // Select the 32-bit instruction word out of a 64-bit memory line.
    function automatic logic [31:0] fetch_word(input logic [DATA_W-1:0] line, input logic hi);
        logic [31:0] w;
        if (hi) begin
            w = line[63:32];
        end else begin
            w = line[31:0];
        end
        return w;
    endfunction

    // Instructions are 4-byte aligned; the two lowest address bits carry no information.
    assign addr_unused_s = ^if_addr[1:0];

    assign wait_f_s = (state_r == WAIT_F);
    assign wait_d_s = (state_r == WAIT_D);
    assign done_s   = capture_s | expire_s;

    assign if_ready  = if_ready_r;
    assign if_rdata  = if_rdata_r;
    assign dm_ready  = dm_ready_r;
    assign dm_rdata  = dm_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign err       = err_r;
    assign stall_f   = if_req & ~if_ready_r;
    assign stall_m   = dm_req & ~dm_ready_r;

    // Next-state logic: arbitration in IDLE, response/timeout detection in WAIT.
    always_comb begin
        state_nxt_s = state_r;
        grant_f_s   = 1'b0;
        grant_d_s   = 1'b0;
        capture_s   = 1'b0;
        expire_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (dm_req && !(if_req && (streak_r == SW'(MAX_DSTREAK)))) begin
                    grant_d_s   = 1'b1;
                    state_nxt_s = WAIT_D;
                end else if (if_req) begin
                    grant_f_s   = 1'b1;
                    state_nxt_s = WAIT_F;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_F, WAIT_D: begin
                if (mem_valid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = (state_r == WAIT_F) ? RESP_F : RESP_D;
                end else if (tmo_cnt_r == CW'(TIMEOUT)) begin
                    expire_s    = 1'b1;
                    state_nxt_s = (state_r == WAIT_F) ? RESP_F : RESP_D;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RESP_F, RESP_D: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Consecutive data grants while fetch waits; saturates at MAX_DSTREAK.
    always_ff @(posedge clk) begin
        if (!reset) begin
            streak_r <= {SW{1'b0}};
        end else if (grant_f_s) begin
            streak_r <= {SW{1'b0}};
        end else if (grant_d_s) begin
            if (!if_req) begin
                streak_r <= {SW{1'b0}};
            end else if (streak_r != SW'(MAX_DSTREAK)) begin
                streak_r <= streak_r + SW'(1);
            end else begin
                streak_r <= streak_r;
            end
        end else begin
            streak_r <= streak_r;
        end
    end

    // Cycles spent waiting for mem_valid in the current transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if (grant_f_s || grant_d_s) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if (wait_f_s || wait_d_s) begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Issue registers: loaded from the winner on a grant, held until the next grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_be_r    <= {BE_W{1'b0}};
            fsel_r      <= 1'b0;
        end else begin
            mem_en_r <= grant_f_s | grant_d_s;
            if (grant_d_s) begin
                mem_we_r    <= dm_we;
                mem_addr_r  <= dm_addr;
                mem_wdata_r <= dm_wdata;
                mem_be_r    <= dm_we ? dm_be : {BE_W{1'b1}};
                fsel_r      <= fsel_r;
            end else if (grant_f_s) begin
                mem_we_r    <= 1'b0;
                mem_addr_r  <= {if_addr[ADDR_W-1:3], 3'b000};
                mem_wdata_r <= {DATA_W{1'b0}};
                mem_be_r    <= {BE_W{1'b1}};
                fsel_r      <= if_addr[2];
            end else begin
                mem_we_r    <= mem_we_r;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
                mem_be_r    <= mem_be_r;
                fsel_r      <= fsel_r;
            end
        end
    end

    // Completion pulses, captured read data and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_ready_r <= 1'b0;
            dm_ready_r <= 1'b0;
            if_rdata_r <= 32'h0000_0000;
            dm_rdata_r <= {DATA_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if_ready_r <= done_s & wait_f_s;
            dm_ready_r <= done_s & wait_d_s;
            if (capture_s && wait_f_s) begin
                if_rdata_r <= fetch_word(mem_rdata, fsel_r);
            end else if (expire_s && wait_f_s) begin
                if_rdata_r <= 32'h0000_0000;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (capture_s && wait_d_s && !mem_we_r) begin
                dm_rdata_r <= mem_rdata;
            end else if (expire_s && wait_d_s) begin
                dm_rdata_r <= {DATA_W{1'b0}};
            end else begin
                dm_rdata_r <= dm_rdata_r;
            end
            if (expire_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule
